sata_dcr_mp: RTL

Multi-port successor of the single-port SATA DCR register interface. It provides one host-visible register window per SATA port (C_NUM_PORTS ports), each containing:
- link/PLL status with change detection;
- a maskable W1C interrupt status;
- a DMA request engine with a handshake FSM and timeout;
- a COMRESET request pulse;
- an 8-word RX FIS read window.

It sits between the DCR/bus slave and the per-port link/DMA logic. Everything runs in sys_clk; phy-domain crossing of StartComm/phyreset is done downstream.

---
 rtl/sata_dcr_pkg.sv | 39 +++
 rtl/sata_dcr_port.sv | 139 +++++++++++++
 rtl/sata_dcr_mp.sv | 97 +++++++++
 3 files changed

// File: rtl/sata_dcr_pkg.sv
// Register map, bit positions and DMA FSM encoding shared by the multi-port SATA DCR block.
package sata_dcr_pkg;

    localparam logic [5:0] REG_STAT     = 6'h00;
    localparam logic [5:0] REG_DMA_CTRL = 6'h04;
    localparam logic [5:0] REG_DMA_ADDR = 6'h08;
    localparam logic [5:0] REG_IRQ_EN   = 6'h0C;
    localparam logic [5:0] REG_TMO      = 6'h10;

    localparam int STAT_HDR_LSB   = 0;
    localparam int STAT_ERR_LSB   = 12;
    localparam int STAT_LINKUP    = 28;
    localparam int STAT_PLLLOCK   = 29;
    localparam int STAT_RXFIFO    = 30;
    localparam int STAT_CXFIFO    = 31;
    localparam int STAT_STARTCOMM = 29;
    localparam int STAT_CXOK      = 30;
    localparam int STAT_CXACK     = 31;

    localparam int IRQ_LSB        = 20;
    localparam int IRQ_W          = 5;
    localparam int IRQ_LINKUP_CG  = 0;
    localparam int IRQ_PLLLOCK_CG = 1;
    localparam int IRQ_DMA_DONE   = 2;
    localparam int IRQ_DMA_TMO    = 3;
    localparam int IRQ_DMA_OVR    = 4;

    localparam int CTRL_LEN_LSB   = 0;
    localparam int CTRL_PM_LSB    = 16;
    localparam int CTRL_FLAGS_LSB = 23;
    localparam int CTRL_GO        = 30;
    localparam int CTRL_PHYRST    = 31;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } dma_state_e;

endpackage

// File: rtl/sata_dcr_port.sv
// One port's register window: status/change detect, W1C interrupts, DMA request FSM with timeout.
module sata_dcr_port
    import sata_dcr_pkg::*;
#(
    parameter int C_TMO_W = 16
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         wr_en,
    input  logic [5:0]   reg_off,
    input  logic [31:0]  writedata,
    input  logic         linkup,
    input  logic         plllock,
    input  logic [3:0]   error_code,
    input  logic [11:0]  rxfifo_fis_hdr,
    input  logic         rxfifo_irq,
    input  logic         cxfifo_irq,
    input  logic [31:0]  rxfis_rdata,
    output logic [31:0]  rdata,
    output logic         irq_pend,
    output logic         cxfifo_ack,
    output logic         cxfifo_ok,
    output logic         start_comm,
    output logic         phyreset,
    output logic [31:0]  dma_address,
    output logic [15:0]  dma_length,
    output logic [3:0]   dma_pm,
    output logic [6:0]   dma_flags,
    output logic         dma_req,
    input  logic         dma_ack
);

    // [0] first sync flop, [1] synchronised value, [2] previous value for edge detect
    logic [2:0]         lk_sync, pl_sync;
    logic [IRQ_W-1:0]   irq_stat, irq_en, irq_set, irq_clr;
    logic [C_TMO_W-1:0] tmo, tmo_cnt;
    dma_state_e         state;
    logic               wr_stat, wr_ctrl, go, expire, busy;

    assign wr_stat  = wr_en && (reg_off == REG_STAT);
    assign wr_ctrl  = wr_en && (reg_off == REG_DMA_CTRL);
    assign go       = writedata[CTRL_GO];
    assign busy     = (state == ST_REQ);
    assign expire   = (tmo != '0) && ((tmo_cnt + C_TMO_W'(1)) == tmo);
    assign irq_pend = |(irq_stat & irq_en);
    assign irq_clr  = wr_stat ? writedata[IRQ_LSB +: IRQ_W] : '0;

    always_comb begin
        irq_set                 = '0;
        irq_set[IRQ_LINKUP_CG]  = lk_sync[1] ^ lk_sync[2];
        irq_set[IRQ_PLLLOCK_CG] = pl_sync[1] ^ pl_sync[2];
        irq_set[IRQ_DMA_DONE]   = busy && dma_ack;
        irq_set[IRQ_DMA_TMO]    = busy && !dma_ack && expire;
        irq_set[IRQ_DMA_OVR]    = busy && wr_ctrl && go;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lk_sync     <= '0;
            pl_sync     <= '0;
            irq_stat    <= '0;
            irq_en      <= '0;
            tmo         <= '0;
            tmo_cnt     <= '0;
            state       <= ST_IDLE;
            cxfifo_ack  <= 1'b0;
            cxfifo_ok   <= 1'b0;
            start_comm  <= 1'b0;
            phyreset    <= 1'b0;
            dma_address <= '0;
            dma_length  <= '0;
            dma_pm      <= '0;
            dma_flags   <= '0;
            dma_req     <= 1'b0;
        end else begin
            lk_sync    <= {lk_sync[1:0], linkup};
            pl_sync    <= {pl_sync[1:0], plllock};
            irq_stat   <= (irq_stat & ~irq_clr) | irq_set;
            cxfifo_ack <= wr_stat && writedata[STAT_CXACK];
            cxfifo_ok  <= wr_stat && writedata[STAT_CXOK];
            start_comm <= wr_stat && writedata[STAT_STARTCOMM];
            if (wr_en && reg_off == REG_DMA_ADDR) dma_address <= writedata;
            if (wr_en && reg_off == REG_IRQ_EN)   irq_en      <= writedata[IRQ_LSB +: IRQ_W];
            if (wr_en && reg_off == REG_TMO)      tmo         <= writedata[C_TMO_W-1:0];
            // a go while a request is outstanding is an overrun and must not disturb the fields
            if (wr_ctrl && !(go && busy)) begin
                dma_length <= writedata[CTRL_LEN_LSB +: 16];
                dma_pm     <= writedata[CTRL_PM_LSB +: 4];
                dma_flags  <= writedata[CTRL_FLAGS_LSB +: 7];
                phyreset   <= writedata[CTRL_PHYRST];
            end
            case (state)
                ST_IDLE: if (wr_ctrl && go) begin
                    state   <= ST_REQ;
                    dma_req <= 1'b1;
                    tmo_cnt <= '0;
                end
                ST_REQ: if (dma_ack || expire) begin
                    state   <= ST_IDLE;
                    dma_req <= 1'b0;
                end else begin
                    tmo_cnt <= tmo_cnt + C_TMO_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (reg_off[5]) begin
            rdata = rxfis_rdata;
        end else begin
            case (reg_off)
                REG_STAT: begin
                    rdata[STAT_HDR_LSB +: 12]  = rxfifo_fis_hdr;
                    rdata[STAT_ERR_LSB +: 4]   = error_code;
                    rdata[IRQ_LSB +: IRQ_W]    = irq_stat;
                    rdata[STAT_LINKUP]         = lk_sync[1];
                    rdata[STAT_PLLLOCK]        = pl_sync[1];
                    rdata[STAT_RXFIFO]         = rxfifo_irq;
                    rdata[STAT_CXFIFO]         = cxfifo_irq;
                end
                REG_DMA_CTRL: begin
                    rdata[CTRL_LEN_LSB +: 16]  = dma_length;
                    rdata[CTRL_PM_LSB +: 4]    = dma_pm;
                    rdata[CTRL_FLAGS_LSB +: 7] = dma_flags;
                    rdata[CTRL_GO]             = busy;
                    rdata[CTRL_PHYRST]         = phyreset;
                end
                REG_DMA_ADDR: rdata = dma_address;
                REG_IRQ_EN:   rdata[IRQ_LSB +: IRQ_W] = irq_en;
                REG_TMO:      rdata[C_TMO_W-1:0] = tmo;
                default:      rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/sata_dcr_mp.sv
// Multi-port SATA DCR register interface: port decode, registered read mux and interrupt OR.
module sata_dcr_mp
    import sata_dcr_pkg::*;
#(
    parameter int C_NUM_PORTS      = 2,
    parameter int C_TMO_W          = 16,
    parameter int C_SATA_CHIPSCOPE = 0
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [7:0]                   address,
    input  logic                         write,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         irq,
    input  logic [C_NUM_PORTS-1:0]       linkup,
    input  logic [C_NUM_PORTS-1:0]       plllock,
    input  logic [C_NUM_PORTS-1:0][3:0]  error_code,
    input  logic [C_NUM_PORTS-1:0][11:0] rxfifo_fis_hdr,
    input  logic [C_NUM_PORTS-1:0]       rxfifo_irq,
    input  logic [C_NUM_PORTS-1:0]       cxfifo_irq,
    output logic [C_NUM_PORTS-1:0]       cxfifo_ack,
    output logic [C_NUM_PORTS-1:0]       cxfifo_ok,
    output logic [C_NUM_PORTS-1:0]       StartComm,
    output logic [C_NUM_PORTS-1:0]       phyreset,
    output logic [C_NUM_PORTS-1:0][31:0] dma_address,
    output logic [C_NUM_PORTS-1:0][15:0] dma_length,
    output logic [C_NUM_PORTS-1:0][3:0]  dma_pm,
    output logic [C_NUM_PORTS-1:0][6:0]  dma_flags,
    output logic [C_NUM_PORTS-1:0]       dma_req,
    input  logic [C_NUM_PORTS-1:0]       dma_ack,
    input  logic [C_NUM_PORTS-1:0][31:0] rxfis_rdata,
    output logic [2:0]                   rxfis_raddr
);

    logic [1:0]                   port_sel;
    logic [C_NUM_PORTS-1:0]       wr_en, port_irq;
    logic [C_NUM_PORTS-1:0][31:0] port_rdata;
    logic [31:0]                  rd_mux;
    logic                         unused_addr;

    assign port_sel    = address[7:6];
    assign rxfis_raddr = address[4:2];
    assign unused_addr = &{1'b0, address[1:0]};

    // debug taps were never carried over; the parameter is accepted and ignored
    if (C_SATA_CHIPSCOPE != 0) begin : g_chipscope
    end

    for (genvar p = 0; p < C_NUM_PORTS; p++) begin : g_port
        assign wr_en[p] = write && (port_sel == 2'(p));
        sata_dcr_port #(.C_TMO_W(C_TMO_W)) u_port (
            .sys_clk        (sys_clk),
            .sys_rst        (sys_rst),
            .wr_en          (wr_en[p]),
            .reg_off        (address[5:0]),
            .writedata      (writedata),
            .linkup         (linkup[p]),
            .plllock        (plllock[p]),
            .error_code     (error_code[p]),
            .rxfifo_fis_hdr (rxfifo_fis_hdr[p]),
            .rxfifo_irq     (rxfifo_irq[p]),
            .cxfifo_irq     (cxfifo_irq[p]),
            .rxfis_rdata    (rxfis_rdata[p]),
            .rdata          (port_rdata[p]),
            .irq_pend       (port_irq[p]),
            .cxfifo_ack     (cxfifo_ack[p]),
            .cxfifo_ok      (cxfifo_ok[p]),
            .start_comm     (StartComm[p]),
            .phyreset       (phyreset[p]),
            .dma_address    (dma_address[p]),
            .dma_length     (dma_length[p]),
            .dma_pm         (dma_pm[p]),
            .dma_flags      (dma_flags[p]),
            .dma_req        (dma_req[p]),
            .dma_ack        (dma_ack[p])
        );
    end

    // unpopulated port windows fall through to 0
    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < C_NUM_PORTS; p++)
            if (port_sel == 2'(p)) rd_mux = port_rdata[p];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= |port_irq;
        end
    end

endmodule
